cc_tag_sched: RTL and testbench

- Sequencer/arbiter in front of one ccTag set (WAYS way instances sharing read/write addresses).
- Runs the post-reset/flush init sweep over all 128 sets.
- Arbitrates the single tag write path between snoop invalidations and line fills, with a fill FIFO.
- Captures the expunged (victim) line address from way results into a one-entry eviction buffer with a valid/ack handshake.

---
 rtl/cc_tag_sched_if.sv | 48 ++++
 rtl/cc_tag_sched.sv | 177 +++++++++++++++++
 tb/tb_cc_tag_sched.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cc_tag_sched_if.sv
// Request/response bundle between the ccTag sequencer and its neighbours:
// lookup/fill/invalidate requesters, the way array, and the eviction consumer.
interface cc_tag_sched_if #(
    parameter int WAYS  = 8,
    parameter int LADDR = 37
);
    logic                    start_init;
    logic                    init_busy;
    logic                    rd_req;
    logic [LADDR-1:0]        rd_addr;
    logic                    rd_gnt;
    logic                    fill_req;
    logic [LADDR-1:0]        fill_addr;
    logic                    fill_rdy;
    logic                    inv_req;
    logic [LADDR-1:0]        inv_addr;
    logic                    inv_rdy;
    logic                    tag_read_clkEn;
    logic [LADDR-1:0]        tag_read_phys_addr;
    logic [LADDR-1:0]        tag_write_phys_addr;
    logic                    tag_write_wen;
    logic                    tag_invalidate;
    logic                    tag_init;
    logic [WAYS-1:0]         tag_write_hit;
    logic [WAYS-1:0]         tag_exp_en;
    logic [WAYS*LADDR-1:0]   tag_expun_addr;
    logic                    evict_valid;
    logic [LADDR-1:0]        evict_addr;
    logic                    evict_inv;
    logic                    evict_ack;
    logic                    err_multi;

    modport slave (
        input  start_init, rd_req, rd_addr, fill_req, fill_addr, inv_req, inv_addr,
               tag_write_hit, tag_exp_en, tag_expun_addr, evict_ack,
        output init_busy, rd_gnt, fill_rdy, inv_rdy, tag_read_clkEn, tag_read_phys_addr,
               tag_write_phys_addr, tag_write_wen, tag_invalidate, tag_init,
               evict_valid, evict_addr, evict_inv, err_multi
    );

    modport master (
        output start_init, rd_req, rd_addr, fill_req, fill_addr, inv_req, inv_addr,
               tag_write_hit, tag_exp_en, tag_expun_addr, evict_ack,
        input  init_busy, rd_gnt, fill_rdy, inv_rdy, tag_read_clkEn, tag_read_phys_addr,
               tag_write_phys_addr, tag_write_wen, tag_invalidate, tag_init,
               evict_valid, evict_addr, evict_inv, err_multi
    );
endinterface

// File: rtl/cc_tag_sched.sv
// Sequencer for one ccTag set: init sweep, invalidate/fill arbitration of the
// shared tag write port, and a one-entry victim buffer. State moves on negedge clk.
module cc_tag_sched #(
    parameter int WAYS   = 8,
    parameter int FILL_Q = 4,
    parameter int LADDR  = 37
) (
    input  logic         clk,
    input  logic         rst,
    cc_tag_sched_if.slave bus
);
    localparam int PW = $clog2(FILL_Q);
    localparam int CW = $clog2(FILL_Q + 1);

    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_HOLD} wstate_e;

    wstate_e          state, state_nx;
    logic             init_busy;
    logic [7:0]       init_cnt;
    logic [LADDR-1:0] fifo_mem [FILL_Q];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    fifo_cnt;
    logic             fill_rdy, push, pop;
    logic             inv_pend, inv_take, inv_done;
    logic [LADDR-1:0] inv_addr_q;
    logic             op_inv, op_ready;
    logic             issue_inv, issue_fill, ev_load, err_set;
    logic             any_exp, multi_exp;
    logic [LADDR-1:0] exp_addr;
    logic             evict_valid, evict_inv, err_multi;
    logic [LADDR-1:0] evict_addr;

    // Sweep: 128 init strobes, then two extra busy cycles for the ways' init pipeline.
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(negedge clk) begin
        if (rst) begin
            init_busy <= 1'b0;
            init_cnt  <= '0;
        end else if (!init_busy) begin
            if (bus.start_init) begin
                init_busy <= 1'b1;
                init_cnt  <= '0;
            end
        end else begin
            if (init_cnt == 8'd129) init_busy <= 1'b0;
            init_cnt <= init_cnt + 8'd1;
        end
    end

    assign fill_rdy = (fifo_cnt != CW'(FILL_Q));
    assign push     = bus.fill_req & fill_rdy;

    // NOTE: the storage array is deliberately not reset; occupancy is defined only by
    // the pointers and count, and an unreset array maps onto plain RAM/flop arrays.
    always_ff @(negedge clk) begin
        if (push) fifo_mem[wr_ptr] <= bus.fill_addr;
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            wr_ptr   <= wr_ptr + PW'(push);
            rd_ptr   <= rd_ptr + PW'(pop);
            fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
        end
    end

    assign inv_take = bus.inv_req & ~inv_pend;

    always_ff @(negedge clk) begin
        if (rst) begin
            inv_pend   <= 1'b0;
            inv_addr_q <= '0;
        end else if (inv_take) begin
            inv_pend   <= 1'b1;
            inv_addr_q <= bus.inv_addr;
        end else if (inv_done) begin
            inv_pend   <= 1'b0;
        end
    end

    // Victim select: lowest-indexed way wins; x & (x-1) is nonzero iff two or more bits set.
    always_comb begin
        exp_addr = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (bus.tag_exp_en[w]) exp_addr = bus.tag_expun_addr[w*LADDR +: LADDR];
        end
    end

    assign any_exp   = |bus.tag_exp_en;
    assign multi_exp = (bus.tag_exp_en & (bus.tag_exp_en - WAYS'(1))) != '0;
    assign op_ready  = inv_pend | (fifo_cnt != '0);

    // NOTE: every output of this block gets a default first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx   = state;
        issue_inv  = 1'b0;
        issue_fill = 1'b0;
        inv_done   = 1'b0;
        pop        = 1'b0;
        ev_load    = 1'b0;
        err_set    = 1'b0;
        case (state)
            W_IDLE, W_HOLD: begin
                if (op_ready && !init_busy) begin
                    if (evict_valid) begin
                        state_nx = W_HOLD;
                    end else begin
                        state_nx   = W_WAIT;
                        issue_inv  = inv_pend;
                        issue_fill = ~inv_pend;
                    end
                end else begin
                    state_nx = W_IDLE;
                end
            end
            W_WAIT: begin
                state_nx = W_IDLE;
                ev_load  = any_exp;
                err_set  = multi_exp;
                inv_done = op_inv;
                pop      = ~op_inv & (|bus.tag_write_hit);
            end
            default: state_nx = W_IDLE;
        endcase
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            state  <= W_IDLE;
            op_inv <= 1'b0;
        end else begin
            state <= state_nx;
            if (issue_inv || issue_fill) op_inv <= issue_inv;
        end
    end

    // Load and ack never coincide: an op only issues while the buffer is empty.
    always_ff @(negedge clk) begin
        if (rst) begin
            evict_valid <= 1'b0;
            evict_addr  <= '0;
            evict_inv   <= 1'b0;
            err_multi   <= 1'b0;
        end else begin
            if (ev_load) begin
                evict_valid <= 1'b1;
                evict_addr  <= exp_addr;
                evict_inv   <= op_inv;
            end else if (bus.evict_ack && evict_valid) begin
                evict_valid <= 1'b0;
            end
            if (err_set) err_multi <= 1'b1;
        end
    end

    assign bus.init_busy           = init_busy;
    assign bus.tag_init            = init_busy & ~init_cnt[7];
    assign bus.rd_gnt              = bus.rd_req & ~init_busy;
    assign bus.tag_read_clkEn      = bus.rd_req & ~init_busy;
    assign bus.tag_read_phys_addr  = bus.rd_addr;
    assign bus.tag_write_phys_addr = init_busy ? LADDR'(init_cnt[6:0]) :
                                     inv_pend  ? inv_addr_q : fifo_mem[rd_ptr];
    assign bus.tag_write_wen       = issue_fill;
    assign bus.tag_invalidate      = issue_inv;
    assign bus.fill_rdy            = fill_rdy;
    assign bus.inv_rdy             = ~inv_pend;
    assign bus.evict_valid         = evict_valid;
    assign bus.evict_addr          = evict_addr;
    assign bus.evict_inv           = evict_inv;
    assign bus.err_multi           = err_multi;
endmodule

// File: tb/tb_cc_tag_sched.sv
// Scoreboard bench for cc_tag_sched: directed stimulus queues expected strobes and
// evictions; monitor processes compare them whenever the DUT presents them.
module tb_cc_tag_sched;
    localparam int WAYS   = 8;
    localparam int FILL_Q = 4;
    localparam int LADDR  = 37;

    typedef struct { logic is_inv; logic [LADDR-1:0] addr; } wr_t;
    typedef struct { logic [WAYS-1:0] hit; logic [WAYS-1:0] exp; logic [WAYS*LADDR-1:0] addrs; } resp_t;
    typedef struct { logic [LADDR-1:0] addr; logic inv; } ev_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   wr_cyc_last = 0;
    int   wr_cyc_prev = 0;

    wr_t              exp_wr[$];
    resp_t            resp_q[$];
    ev_t              exp_ev[$];
    logic [LADDR-1:0] exp_init[$];

    cc_tag_sched_if #(.WAYS(WAYS), .LADDR(LADDR)) bus ();

    cc_tag_sched #(.WAYS(WAYS), .FILL_Q(FILL_Q), .LADDR(LADDR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic exp_write(input logic is_inv, input logic [LADDR-1:0] a);
        wr_t w;
        w.is_inv = is_inv;
        w.addr   = a;
        exp_wr.push_back(w);
    endtask

    task automatic exp_resp(input logic [WAYS-1:0] hit, input logic [WAYS-1:0] exp,
                            input logic [WAYS*LADDR-1:0] addrs);
        resp_t r;
        r.hit   = hit;
        r.exp   = exp;
        r.addrs = addrs;
        resp_q.push_back(r);
    endtask

    task automatic exp_evict(input logic [LADDR-1:0] a, input logic inv);
        ev_t e;
        e.addr = a;
        e.inv  = inv;
        exp_ev.push_back(e);
    endtask

    task automatic exp_sweep();
        for (int i = 0; i < 128; i++) exp_init.push_back(LADDR'(i));
    endtask

    task automatic push_fill(input logic [LADDR-1:0] a);
        bus.fill_req  = 1'b1;
        bus.fill_addr = a;
        tick();
        bus.fill_req  = 1'b0;
    endtask

    task automatic ack_evict();
        tick();
        bus.evict_ack = 1'b1;
        tick();
        bus.evict_ack = 1'b0;
    endtask

    task automatic wait_evict(input string name);
        int n = 0;
        while (!bus.evict_valid && n < 50) begin
            @(posedge clk);
            n++;
        end
        check(name, bus.evict_valid, 1'b1);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((exp_wr.size() != 0 || exp_ev.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        check(name, (n < budget), 1'b1);
        repeat (4) @(posedge clk);
    endtask

    // Monitor: every strobe or new eviction is matched against the head of its queue.
    initial begin : monitor
        wr_t              w;
        ev_t              e;
        logic [LADDR-1:0] ia;
        logic             prev_ev;
        prev_ev = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            if (bus.tag_init === 1'b1) begin
                if (exp_init.size() == 0) check("unexpected_init", bus.tag_init, 1'b0);
                else begin
                    ia = exp_init.pop_front();
                    check("init_addr", bus.tag_write_phys_addr, ia);
                end
            end
            if (bus.tag_write_wen === 1'b1 || bus.tag_invalidate === 1'b1) begin
                wr_cyc_prev = wr_cyc_last;
                wr_cyc_last = cyc;
                if (exp_wr.size() == 0) check("unexpected_write", bus.tag_write_wen | bus.tag_invalidate, 1'b0);
                else begin
                    w = exp_wr.pop_front();
                    check("wr_is_inv", bus.tag_invalidate, w.is_inv);
                    check("wr_addr", bus.tag_write_phys_addr, w.addr);
                end
            end
            if (bus.evict_valid === 1'b1 && !prev_ev) begin
                if (exp_ev.size() == 0) check("unexpected_evict", bus.evict_valid, 1'b0);
                else begin
                    e = exp_ev.pop_front();
                    check("evict_addr", bus.evict_addr, e.addr);
                    check("evict_inv", bus.evict_inv, e.inv);
                end
            end
            prev_ev = (bus.evict_valid === 1'b1);
        end
    end

    // Way model: answers each issued write during the following (W_WAIT) cycle.
    initial begin : responder
        resp_t r;
        bus.tag_write_hit  = '0;
        bus.tag_exp_en     = '0;
        bus.tag_expun_addr = '0;
        forever begin
            @(posedge clk);
            if (bus.tag_write_wen === 1'b1 || bus.tag_invalidate === 1'b1) begin
                if (resp_q.size() != 0) r = resp_q.pop_front();
                else begin
                    r.hit = '0; r.exp = '0; r.addrs = '0;
                end
                @(negedge clk);
                #1;
                bus.tag_write_hit  = r.hit;
                bus.tag_exp_en     = r.exp;
                bus.tag_expun_addr = r.addrs;
                @(negedge clk);
                #1;
                bus.tag_write_hit  = '0;
                bus.tag_exp_en     = '0;
                bus.tag_expun_addr = '0;
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int                    busy_n, init_n, gnt_n;
        logic                  any_strobe;
        logic [WAYS*LADDR-1:0] flat;

        rst = 1'b1;
        bus.start_init = 1'b0; bus.rd_req = 1'b0; bus.rd_addr = '0;
        bus.fill_req = 1'b0; bus.fill_addr = '0; bus.inv_req = 1'b0; bus.inv_addr = '0;
        bus.evict_ack = 1'b0;
        tick();
        tick();
        @(posedge clk);
        check("rst_init_busy", bus.init_busy, 1'b0);
        check("rst_rd_gnt", bus.rd_gnt, 1'b0);
        check("rst_strobes", {bus.tag_init, bus.tag_write_wen, bus.tag_invalidate}, 3'b000);
        check("rst_evict_valid", bus.evict_valid, 1'b0);
        check("rst_evict_addr", bus.evict_addr, '0);
        check("rst_fill_rdy", bus.fill_rdy, 1'b1);
        check("rst_inv_rdy", bus.inv_rdy, 1'b1);
        check("rst_err_multi", bus.err_multi, 1'b0);
        tick();
        rst = 1'b0;

        // Init sweep with a lookup held pending; start_init stays high into the sweep.
        exp_sweep();
        bus.rd_req  = 1'b1;
        bus.rd_addr = 37'h5;
        bus.start_init = 1'b1;
        busy_n = 0; init_n = 0; gnt_n = 0;
        fork
            begin
                repeat (2) tick();
                bus.start_init = 1'b0;
            end
            begin
                for (int i = 0; i < 400; i++) begin
                    @(posedge clk);
                    if (!bus.init_busy && busy_n > 0) break;
                    if (bus.init_busy) busy_n++;
                    if (bus.tag_init) init_n++;
                    if (bus.init_busy && bus.rd_gnt) gnt_n++;
                end
            end
        join
        check("init_busy_cycles", busy_n, 130);
        check("tag_init_cycles", init_n, 128);
        check("rd_gnt_during_init", gnt_n, 0);
        check("rd_gnt_after_init", bus.rd_gnt, 1'b1);
        check("rd_clken_after_init", bus.tag_read_clkEn, 1'b1);
        check("rd_addr_pass", bus.tag_read_phys_addr, 37'h5);
        tick();
        bus.rd_req = 1'b0;

        // Fill that hits and evicts way 3's line.
        flat = '0;
        flat[3*LADDR +: LADDR] = 37'h0ABCD;
        exp_write(1'b0, 37'h12345);
        exp_resp(8'b0000_1000, 8'b0000_1000, flat);
        exp_evict(37'h0ABCD, 1'b0);
        push_fill(37'h12345);
        wait_evict("evict_timeout_fill");
        check("evict_addr_fill", bus.evict_addr, 37'h0ABCD);
        check("fill_rdy_after_pop", bus.fill_rdy, 1'b1);
        ack_evict();
        @(posedge clk);
        check("evict_cleared", bus.evict_valid, 1'b0);
        wait_drain("drain_fill_evict", 20);

        // Back-pressure: buffer occupied, then invalidate and fill both pending.
        flat = '0;
        flat[0 +: LADDR] = 37'h777;
        exp_write(1'b0, 37'h200);
        exp_resp(8'b0000_0001, 8'b0000_0001, flat);
        exp_evict(37'h777, 1'b0);
        push_fill(37'h200);
        wait_evict("evict_timeout_hold");
        tick();
        bus.inv_req = 1'b1; bus.inv_addr = 37'h300;
        bus.fill_req = 1'b1; bus.fill_addr = 37'h400;
        tick();
        bus.inv_req = 1'b0; bus.fill_req = 1'b0;
        any_strobe = 1'b0;
        repeat (6) begin
            @(posedge clk);
            any_strobe = any_strobe | bus.tag_write_wen | bus.tag_invalidate;
        end
        check("hold_no_strobe", any_strobe, 1'b0);
        check("hold_inv_rdy", bus.inv_rdy, 1'b0);
        exp_write(1'b1, 37'h300);
        exp_resp('0, '0, '0);
        exp_write(1'b0, 37'h400);
        exp_resp(8'b0001_0000, '0, '0);
        ack_evict();
        wait_drain("drain_priority", 30);
        check("priority_inv_rdy", bus.inv_rdy, 1'b1);

        // Fill that misses is retried two cycles later, then pops on the hit.
        exp_write(1'b0, 37'h00100);
        exp_resp('0, '0, '0);
        exp_write(1'b0, 37'h00100);
        exp_resp(8'b1000_0000, '0, '0);
        push_fill(37'h00100);
        wait_drain("drain_retry", 30);
        check("retry_gap", wr_cyc_last - wr_cyc_prev, 2);

        // FIFO fills up during a sweep; the fifth push is dropped.
        exp_sweep();
        for (int i = 0; i < 4; i++) begin
            exp_write(1'b0, LADDR'(37'hA01 + i));
            exp_resp(8'b0000_0010, '0, '0);
        end
        bus.start_init = 1'b1;
        tick();
        bus.start_init = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.fill_req  = 1'b1;
            bus.fill_addr = LADDR'(37'hA01 + i);
            @(posedge clk);
            check("fill_rdy_pre_push", bus.fill_rdy, (i < 4));
            tick();
        end
        bus.fill_req = 1'b0;
        @(posedge clk);
        check("fifo_full_rdy", bus.fill_rdy, 1'b0);
        check("fifo_full_busy", bus.init_busy, 1'b1);
        wait_drain("drain_fifo_full", 400);
        check("fifo_drained_rdy", bus.fill_rdy, 1'b1);

        // Two ways report exp_en: lowest wins and the error flag latches.
        flat = '0;
        flat[2*LADDR +: LADDR] = 37'h222;
        flat[5*LADDR +: LADDR] = 37'h555;
        exp_write(1'b0, 37'hB00);
        exp_resp(8'b0010_0100, 8'b0010_0100, flat);
        exp_evict(37'h222, 1'b0);
        push_fill(37'hB00);
        wait_evict("evict_timeout_multi");
        tick();
        check("multi_err_set", bus.err_multi, 1'b1);
        ack_evict();
        repeat (5) @(posedge clk);
        check("multi_err_sticky", bus.err_multi, 1'b1);
        wait_drain("drain_multi", 20);

        // Reset mid-sweep discards the sweep and any queued fill/invalidate.
        exp_sweep();
        bus.start_init = 1'b1;
        tick();
        bus.start_init = 1'b0;
        bus.inv_req = 1'b1; bus.inv_addr = 37'hD00;
        push_fill(37'hC00);
        bus.inv_req = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_init.delete();
        @(posedge clk);
        check("abort_init_busy", bus.init_busy, 1'b0);
        check("abort_tag_init", bus.tag_init, 1'b0);
        check("abort_err_multi", bus.err_multi, 1'b0);
        check("abort_inv_rdy", bus.inv_rdy, 1'b1);
        repeat (10) @(posedge clk);
        check("leftover_writes", exp_wr.size(), 0);
        check("leftover_evicts", exp_ev.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
